// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-side program-counter unit.
// Instruction length and the default boot address live here so every user agrees on them.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } fetch_state_t;

   localparam int          ILEN_BYTES           = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request channel: a valid/ready handshake carrying the fetch address.
// The master (the PC unit) drives valid and addr; the slave (memory) drives ready.
interface pc_fetch_ctrl_if #(
   parameter int XLEN = 32
);

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready
   );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: trap beats redirect beats sequential advance.
// A misaligned redirect is reported instead of taken, so the PC simply holds.
module pc_next_sel #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] pc_plus4_i,
   input  logic            fire_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic [XLEN-1:0] next_pc_o,
   output logic            take_misalign_o,
   output logic            take_jump_o,
   output logic            advance_o
);

   logic redirectAligned;

   assign redirectAligned = (redirect_pc_i[1:0] == 2'b00);

   always_comb begin
      next_pc_o       = pc_i;
      take_misalign_o = 1'b0;
      take_jump_o     = 1'b0;
      advance_o       = 1'b0;
      if (trap_valid_i) begin
         next_pc_o   = trap_pc_i;
         take_jump_o = 1'b1;
      end else if (redirect_valid_i && redirectAligned) begin
         next_pc_o   = redirect_pc_i;
         take_jump_o = 1'b1;
      end else if (redirect_valid_i) begin
         take_misalign_o = 1'b1;
      end else if (fire_i) begin
         next_pc_o = pc_plus4_i;
         advance_o = 1'b1;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter unit: holds the fetch PC, issues imem requests and handles
// stall, branch/trap redirects, misaligned-target reporting and a fetch counter.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
   parameter int              CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [XLEN-1:0]       redirect_pc,
   input  logic                  trap_valid,
   input  logic [XLEN-1:0]       trap_pc,
   pc_fetch_ctrl_if.master       imem,
   output logic [XLEN-1:0]       pc,
   output logic [XLEN-1:0]       pc_plus4,
   output logic                  misalign,
   output logic [XLEN-1:0]       misalign_addr,
   output logic [CNT_W-1:0]      fetch_count
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] misalign_addr_q;
   logic [CNT_W-1:0] count_q;
   logic            misalign_q;
   logic            fire;
   logic            takeMisalign;
   logic            takeJump;
   logic            advance;

   assign pc            = pc_q;
   assign pc_plus4      = pc_q + XLEN'(ILEN_BYTES);
   assign misalign      = misalign_q;
   assign misalign_addr = misalign_addr_q;
   assign fetch_count   = count_q;

   assign imem.imem_req_valid = (state_q == RUN);
   assign imem.imem_req_addr  = pc_q;
   assign fire                = (state_q == RUN) && imem.imem_req_ready;

   pc_next_sel #(.XLEN(XLEN)) u_next_sel (
      .pc_i             (pc_q),
      .pc_plus4_i       (pc_plus4),
      .fire_i           (fire),
      .trap_valid_i     (trap_valid),
      .trap_pc_i        (trap_pc),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .next_pc_o        (pc_d),
      .take_misalign_o  (takeMisalign),
      .take_jump_o      (takeJump),
      .advance_o        (advance)
   );

   // A taken trap/redirect forces RUN for one cycle even under stall.
   always_comb begin
      state_d = state_q;
      if (takeJump) begin
         state_d = RUN;
      end else begin
         case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = stall ? STALL : RUN;
            STALL:   state_d = stall ? STALL : RUN;
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= BOOT;
         pc_q            <= RESET_VECTOR;
         misalign_q      <= 1'b0;
         misalign_addr_q <= '0;
         count_q         <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= takeMisalign;
         if (takeMisalign) begin
            misalign_addr_q <= redirect_pc;
         end
         if (fire) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   logic unusedAdvance;
   assign unusedAdvance = advance;

endmodule
